hex_display_ctrl: RTL and testbench

Registered, parametrised driver for a bank of active-low seven-segment digits. It succeeds the combinational per-digit decode layer. It adds latched display content, per-digit blinking (e.g. overflow/error indication) and a wrap-around scrolling message mode. It sits between the ALU/datapath front-end and the board HEX pins, and owns all digit decoding internally.

---
 rtl/hex_display_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_hex_display_ctrl.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/hex_display_ctrl.sv
// hex_display_ctrl: registered driver for a bank of active-low seven-segment digits.
// Holds latched static content, per-digit blinking and a wrap-around scrolling message.
// Optional feature macro: HEX_DISPLAY_DP_EN (drive decimal points from dp_in).
//
// Ports:
//   clk          system clock, all state changes on the rising edge
//   rst          synchronous active-high reset
//   load         capture codes_in into the static display register
//   codes_in     5-bit character code per digit, digit i at [5i+4:5i]
//   blink_mask   digits that blank during the blink off-phase (mode 01)
//   mode         00 static, 01 blink, 10 scroll, 11 static
//   msg_load     capture msg_in and restart scrolling
//   msg_in       5-bit scroll message codes, character 0 at [4:0]
//   dp_in        decimal-point request per digit (used only with HEX_DISPLAY_DP_EN)
//   hex_out      {dp,g,f,e,d,c,b,a} per digit at [8i+7:8i], active-low, registered
//   scroll_wrap  one-cycle registered pulse when the scroll offset wraps to 0
module hex_display_ctrl #(
   parameter int unsigned NUM_DIGITS = 6,
   parameter int unsigned MSG_LEN    = 8,
   parameter int unsigned BLINK_DIV  = 25_000_000,
   parameter int unsigned SCROLL_DIV = 12_500_000
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      load,
   input  logic [5*NUM_DIGITS-1:0]   codes_in,
   input  logic [NUM_DIGITS-1:0]     blink_mask,
   input  logic [1:0]                mode,
   input  logic                      msg_load,
   input  logic [5*MSG_LEN-1:0]      msg_in,
   input  logic [NUM_DIGITS-1:0]     dp_in,
   output logic [8*NUM_DIGITS-1:0]   hex_out,
   output logic                      scroll_wrap
);

   localparam int unsigned CW = 5;
   localparam int unsigned BW = (BLINK_DIV  > 1) ? $clog2(BLINK_DIV)  : 1;
   localparam int unsigned SW = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;
   localparam int unsigned OW = (MSG_LEN    > 1) ? $clog2(MSG_LEN)    : 1;

   localparam logic [1:0]  MODE_BLINK  = 2'b01;
   localparam logic [1:0]  MODE_SCROLL = 2'b10;
   localparam logic [4:0]  CODE_BLANK  = 5'h10;

   logic [CW*NUM_DIGITS-1:0] disp, disp_d;
   logic [CW*MSG_LEN-1:0]    msg, msg_d;
   logic [BW-1:0]            blink_cnt, blink_cnt_d;
   logic                     phase, phase_d;
   logic [SW-1:0]            scroll_cnt, scroll_cnt_d;
   logic [OW-1:0]            offset, offset_d;
   logic                     wrap_d;
   logic [8*NUM_DIGITS-1:0]  hex_d;
   logic [NUM_DIGITS-1:0]    dp_q;

   // Character code to active-low segment pattern {dp,g,f,e,d,c,b,a}.
   function automatic logic [7:0] decode(input logic [4:0] code);
      logic [7:0] seg;
      case (code)
         5'h00: seg = 8'hC0;
         5'h01: seg = 8'hF9;
         5'h02: seg = 8'hA4;
         5'h03: seg = 8'hB0;
         5'h04: seg = 8'h99;
         5'h05: seg = 8'h92;
         5'h06: seg = 8'h82;
         5'h07: seg = 8'hF8;
         5'h08: seg = 8'h80;
         5'h09: seg = 8'h90;
         5'h0A: seg = 8'h88;
         5'h0B: seg = 8'h83;
         5'h0C: seg = 8'hC6;
         5'h0D: seg = 8'hA1;
         5'h0E: seg = 8'h86;
         5'h0F: seg = 8'h8E;
         5'h11: seg = 8'hBF;
         5'h12: seg = 8'hB7;
         5'h13: seg = 8'hAF;
         default: seg = 8'hFF;
      endcase
      return seg;
   endfunction

   // Next-state logic for content registers, blink and scroll counters.
   always_comb begin
      disp_d       = disp;
      msg_d        = msg;
      blink_cnt_d  = blink_cnt;
      phase_d      = phase;
      scroll_cnt_d = scroll_cnt;
      offset_d     = offset;
      wrap_d       = 1'b0;

      if (load) disp_d = codes_in;

      if (blink_cnt == BW'(BLINK_DIV - 1)) begin
         blink_cnt_d = '0;
         phase_d     = ~phase;
      end else begin
         blink_cnt_d = blink_cnt + BW'(1);
      end

      // A message reload overrides any coincident scroll step and suppresses the wrap pulse.
      if (msg_load) begin
         msg_d        = msg_in;
         scroll_cnt_d = '0;
         offset_d     = '0;
      end else if (mode == MODE_SCROLL) begin
         if (scroll_cnt == SW'(SCROLL_DIV - 1)) begin
            scroll_cnt_d = '0;
            if (offset == OW'(MSG_LEN - 1)) begin
               offset_d = '0;
               wrap_d   = 1'b1;
            end else begin
               offset_d = offset + OW'(1);
            end
         end else begin
            scroll_cnt_d = scroll_cnt + SW'(1);
         end
      end
   end

   // Output glyph selection from the current registered state.
   always_comb begin
      logic [7:0]  seg;
      logic [4:0]  ch;
      int unsigned idx;
      hex_d = '1;
      for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
         seg = decode(disp[CW*i +: CW]);
         ch  = CODE_BLANK;
         idx = (32'(offset) + NUM_DIGITS - 1 - i) % MSG_LEN;
         if (mode == MODE_SCROLL) begin
            for (int unsigned j = 0; j < MSG_LEN; j++) begin
               if (j == idx) ch = msg[CW*j +: CW];
            end
            seg = decode(ch);
         end else if (mode == MODE_BLINK && phase && blink_mask[i]) begin
            seg = 8'hFF;
         end
`ifdef HEX_DISPLAY_DP_EN
         seg[7] = ~dp_q[i];
`else
         seg[7] = 1'b1;
`endif
         hex_d[8*i +: 8] = seg;
      end
   end

   // State and output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         disp        <= {NUM_DIGITS{CODE_BLANK}};
         msg         <= {MSG_LEN{CODE_BLANK}};
         blink_cnt   <= '0;
         phase       <= 1'b0;
         scroll_cnt  <= '0;
         offset      <= '0;
         hex_out     <= '1;
         scroll_wrap <= 1'b0;
      end else begin
         disp        <= disp_d;
         msg         <= msg_d;
         blink_cnt   <= blink_cnt_d;
         phase       <= phase_d;
         scroll_cnt  <= scroll_cnt_d;
         offset      <= offset_d;
         hex_out     <= hex_d;
         scroll_wrap <= wrap_d;
      end
   end

`ifdef HEX_DISPLAY_DP_EN
   // Decimal-point requests share the glyph path's two-cycle latency.
   always_ff @(posedge clk) begin
      if (rst) dp_q <= '0;
      else     dp_q <= dp_in;
   end
`else
   logic unused_dp;
   assign dp_q      = '0;
   assign unused_dp = ^{dp_in, dp_q};
`endif

endmodule

// File: tb/tb_hex_display_ctrl.sv
module tb_hex_display_ctrl;

   localparam int unsigned ND = 6;
   localparam int unsigned ML = 8;
   localparam int unsigned BD = 4;
   localparam int unsigned SD = 3;
   localparam logic [7:0] HEX_T [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                         8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

   logic            clk = 1'b0;
   logic            rst, load, msg_load;
   logic [5*ND-1:0] codes_in;
   logic [ND-1:0]   blink_mask, dp_in;
   logic [1:0]      mode;
   logic [5*ML-1:0] msg_in;
   logic [8*ND-1:0] hex_out;
   logic            scroll_wrap;

   int checks = 0;
   int errors = 0;

   // Reference model state, updated once per clock from the documented rules.
   int         m_disp [ND];
   int         m_msg  [ML];
   int         m_bcnt, m_phase, m_scnt, m_off;
   logic [5:0] m_dp;

   hex_display_ctrl #(.NUM_DIGITS(ND), .MSG_LEN(ML), .BLINK_DIV(BD), .SCROLL_DIV(SD)) dut (
      .clk(clk), .rst(rst), .load(load), .codes_in(codes_in), .blink_mask(blink_mask),
      .mode(mode), .msg_load(msg_load), .msg_in(msg_in), .dp_in(dp_in),
      .hex_out(hex_out), .scroll_wrap(scroll_wrap));

   always #5 clk = ~clk;

   function automatic logic [7:0] glyph(input int c);
      if (c < 16) return HEX_T[c];
      case (c)
         17: return 8'hBF;
         18: return 8'hB7;
         19: return 8'hAF;
         default: return 8'hFF;
      endcase
   endfunction

   function automatic logic [47:0] model_hex();
      logic [47:0] h;
      logic [7:0]  s;
      h = '1;
      for (int i = 0; i < int'(ND); i++) begin
         if (mode == 2'b10) s = glyph(m_msg[(m_off + int'(ND) - 1 - i) % int'(ML)]);
         else if (mode == 2'b01 && m_phase == 1 && blink_mask[i]) s = 8'hFF;
         else s = glyph(m_disp[i]);
`ifdef HEX_DISPLAY_DP_EN
         s[7] = ~m_dp[i];
`endif
         h[8*i +: 8] = s;
      end
      return h;
   endfunction

   task automatic chk48(input string tag, input logic [47:0] got, input logic [47:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, got, exp);
      end
   endtask

   task automatic chk1(input string tag, input logic got, input logic exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s observed %b expected %b", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < int'(ND); i++) m_disp[i] = 16;
      for (int j = 0; j < int'(ML); j++) m_msg[j] = 16;
      m_bcnt = 0; m_phase = 0; m_scnt = 0; m_off = 0; m_dp = '0;
   endtask

   // One clock: predict outputs from pre-edge state, advance the model, then compare.
   task automatic cyc();
      logic [47:0] nh;
      logic        nw;
      if (rst) begin
         nh = '1;
         nw = 1'b0;
         model_reset();
      end else begin
         nh = model_hex();
         nw = (mode == 2'b10) && !msg_load && (m_scnt == int'(SD) - 1) && (m_off == int'(ML) - 1);
         if (load) for (int i = 0; i < int'(ND); i++) m_disp[i] = int'(codes_in[5*i +: 5]);
         if (msg_load) begin
            for (int j = 0; j < int'(ML); j++) m_msg[j] = int'(msg_in[5*j +: 5]);
            m_scnt = 0;
            m_off  = 0;
         end else if (mode == 2'b10) begin
            if (m_scnt == int'(SD) - 1) begin
               m_scnt = 0;
               m_off  = (m_off + 1) % int'(ML);
            end else m_scnt++;
         end
         if (m_bcnt == int'(BD) - 1) begin
            m_bcnt  = 0;
            m_phase = 1 - m_phase;
         end else m_bcnt++;
         m_dp = dp_in;
      end
      @(posedge clk);
      #1;
      chk48("hex_model", hex_out, nh);
      chk1("wrap_model", scroll_wrap, nw);
   endtask

   initial begin
      int wraps;
      int guard;
      rst = 1'b1; load = 1'b0; msg_load = 1'b0; codes_in = '0; blink_mask = '0;
      mode = 2'b00; msg_in = '0; dp_in = '0;
      model_reset();
      cyc();
      cyc();
      chk48("reset_hex", hex_out, 48'hFFFF_FFFF_FFFF);
      chk1("reset_wrap", scroll_wrap, 1'b0);
      rst = 1'b0;

      // Static load, two-edge latency.
      codes_in = {5'd5, 5'h11, 5'd3, 5'h12, 5'h10, 5'd2};
      load = 1'b1;
      cyc();
      load = 1'b0;
      cyc();
      chk48("static_load", hex_out, 48'h92BF_B0B7_FFA4);

      // Blink on digit0 only.
      codes_in = {5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'hE};
      load = 1'b1;
      cyc();
      load = 1'b0;
      mode = 2'b01;
      blink_mask = 6'b000001;
      repeat (20) begin
         cyc();
         chk48("blink_upper", {8'h00, hex_out[47:8]}, 48'h00F9_A4B0_9992);
      end

      // Scroll message 0..7.
      mode = 2'b00;
      for (int j = 0; j < int'(ML); j++) msg_in[5*j +: 5] = 5'(j);
      msg_load = 1'b1;
      cyc();
      msg_load = 1'b0;
      mode = 2'b10;
      cyc();
      chk48("scroll_step0", hex_out, 48'hC0F9_A4B0_9992);
      wraps = 0;
      repeat (26) begin
         cyc();
         if (scroll_wrap) wraps++;
      end
      chk48("scroll_wrap_count", 48'(wraps), 48'd1);

      // Freeze and resume.
      mode = 2'b00;
      repeat (5) cyc();
      mode = 2'b10;
      repeat (7) cyc();

      // msg_load on the edge where offset would wrap.
      guard = 0;
      while (!(m_off == int'(ML) - 1 && m_scnt == int'(SD) - 1) && guard < 100) begin
         cyc();
         guard++;
      end
      chk1("collision_reached", guard < 100, 1'b1);
      msg_in = {8'($urandom), 32'($urandom)};
      msg_load = 1'b1;
      cyc();
      msg_load = 1'b0;
      chk1("collision_no_wrap", scroll_wrap, 1'b0);
      cyc();
      chk48("collision_left", {40'h0, hex_out[47:40]}, {40'h0, glyph(int'(msg_in[4:0]))});
      chk1("collision_no_wrap2", scroll_wrap, 1'b0);

      // Reset mid-scroll.
      repeat (4) cyc();
      rst = 1'b1;
      cyc();
      cyc();
      chk48("midrst_hex", hex_out, 48'hFFFF_FFFF_FFFF);
      chk1("midrst_wrap", scroll_wrap, 1'b0);
      rst = 1'b0;

      // Decimal point on digit2.
      mode = 2'b00;
      dp_in = 6'b000100;
      cyc();
      cyc();
`ifdef HEX_DISPLAY_DP_EN
      chk1("dp_digit2", hex_out[23], 1'b0);
`else
      chk1("dp_digit2", hex_out[23], 1'b1);
`endif

      // Randomized operation.
      repeat (400) begin
         rst        = ($urandom_range(0, 99) == 0);
         load       = ($urandom_range(0, 7) == 0);
         msg_load   = ($urandom_range(0, 15) == 0);
         codes_in   = 30'($urandom);
         msg_in     = {8'($urandom), 32'($urandom)};
         blink_mask = 6'($urandom);
         dp_in      = 6'($urandom);
         if ($urandom_range(0, 9) == 0) mode = 2'($urandom);
         cyc();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
